// File: rtl/sort_pkg.sv
// Shared defaults and bank state type for the sorted-frame emitter.
// Imported by the bank, the top level and the stream interface.
package sort_pkg;

  localparam int SORT_DATA_WIDTH = 5;
  localparam int SORT_DATA_SIZE  = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  // A bank can take another element unless it already holds a complete frame.
  function automatic logic bank_writable(input bank_state_t state);
    return (state != FULL);
  endfunction

endpackage

// File: rtl/sort_frame_emitter_if.sv
// Valid/ready element stream with an end-of-frame marker.
// The producer side drives valid/data/last and the consumer side drives ready.
interface sort_frame_emitter_if #(
  parameter int DATA_WIDTH = sort_pkg::SORT_DATA_WIDTH
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/sort_frame_bank.sv
// One frame bank: DATA_SIZE element storage plus its EMPTY/FILLING/FULL state.
// A bank is only written while not FULL and only freed while FULL, so the two never coincide.
module sort_frame_bank
  import sort_pkg::*;
#(
  parameter  int DATA_WIDTH = SORT_DATA_WIDTH,
  parameter  int DATA_SIZE  = SORT_DATA_SIZE,
  localparam int IdxW       = $clog2(DATA_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [IdxW-1:0]       wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_last_i,
  input  logic                  rd_free_i,
  input  logic [IdxW-1:0]       rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output bank_state_t           state_o
);

  logic [DATA_WIDTH-1:0] mem_q [DATA_SIZE];
  bank_state_t           state_q;
  bank_state_t           state_d;

  // Element storage; contents survive reset since the state alone marks validity.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Bank state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Bank state transitions on writes and on release of the drained frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (wr_en_i) begin
          state_d = wr_last_i ? FULL : FILLING;
        end else begin
          state_d = EMPTY;
        end
      end
      FILLING: begin
        if (wr_en_i && wr_last_i) begin
          state_d = FULL;
        end else begin
          state_d = FILLING;
        end
      end
      FULL: begin
        if (rd_free_i) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign state_o   = state_q;

endmodule

// File: rtl/sort_frame_emitter.sv
// Ping-pong frame buffer between a sorter and its consumer: collects DATA_SIZE
// elements per frame, emits them with an end marker, and flags descending pairs.
module sort_frame_emitter
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = SORT_DATA_WIDTH,
  parameter int DATA_SIZE  = SORT_DATA_SIZE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  order_err_o,
  output logic [15:0]           frame_cnt_o
);

  localparam int              IdxW     = $clog2(DATA_SIZE);
  localparam logic [IdxW-1:0] IDX_ZERO = {IdxW{1'b0}};
  localparam logic [IdxW-1:0] IDX_ONE  = IdxW'(1);
  localparam logic [IdxW-1:0] IDX_LAST = IdxW'(DATA_SIZE - 1);

  logic                  wr_sel_q, wr_sel_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [IdxW-1:0]       wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]       rd_idx_q, rd_idx_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  order_err_q, order_err_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  bank_state_t           bank0_state, bank1_state;
  bank_state_t           wr_state, rd_state;
  logic [DATA_WIDTH-1:0] bank0_rd_data, bank1_rd_data, rd_data;
  logic                  in_fire, out_fire, wr_last, rd_last;

  // Handshakes depend only on registered bank state and indices.
  assign wr_state    = wr_sel_q ? bank1_state : bank0_state;
  assign rd_state    = rd_sel_q ? bank1_state : bank0_state;
  assign in_ready_o  = bank_writable(wr_state);
  assign out_valid_o = (rd_state == FULL);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;
  assign wr_last     = (wr_idx_q == IDX_LAST);
  assign rd_last     = (rd_idx_q == IDX_LAST);
  assign rd_data     = rd_sel_q ? bank1_rd_data : bank0_rd_data;
  assign out_data_o  = out_valid_o ? rd_data : {DATA_WIDTH{1'b0}};
  assign out_last_o  = out_valid_o && rd_last;
  assign order_err_o = order_err_q;
  assign frame_cnt_o = frame_cnt_q;

  sort_frame_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_SIZE  (DATA_SIZE)
  ) u_bank0 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (in_fire && !wr_sel_q),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (in_data_i),
    .wr_last_i (wr_last),
    .rd_free_i (out_fire && rd_last && !rd_sel_q),
    .rd_idx_i  (rd_idx_q),
    .rd_data_o (bank0_rd_data),
    .state_o   (bank0_state)
  );

  sort_frame_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_SIZE  (DATA_SIZE)
  ) u_bank1 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (in_fire && wr_sel_q),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (in_data_i),
    .wr_last_i (wr_last),
    .rd_free_i (out_fire && rd_last && rd_sel_q),
    .rd_idx_i  (rd_idx_q),
    .rd_data_o (bank1_rd_data),
    .state_o   (bank1_state)
  );

  // Write side: index/bank advance and the in-frame ordering check.
  always_comb begin
    wr_sel_d    = wr_sel_q;
    wr_idx_d    = wr_idx_q;
    prev_d      = prev_q;
    order_err_d = order_err_q;
    if (in_fire) begin
      prev_d = in_data_i;
      if ((wr_idx_q != IDX_ZERO) && (in_data_i < prev_q)) begin
        order_err_d = 1'b1;
      end else begin
        order_err_d = order_err_q;
      end
      if (wr_last) begin
        wr_idx_d = IDX_ZERO;
        wr_sel_d = ~wr_sel_q;
      end else begin
        wr_idx_d = wr_idx_q + IDX_ONE;
      end
    end else begin
      prev_d = prev_q;
    end
  end

  // Read side: index/bank advance and the emitted-frame counter.
  always_comb begin
    rd_sel_d    = rd_sel_q;
    rd_idx_d    = rd_idx_q;
    frame_cnt_d = frame_cnt_q;
    if (out_fire) begin
      if (rd_last) begin
        rd_idx_d    = IDX_ZERO;
        rd_sel_d    = ~rd_sel_q;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        rd_idx_d = rd_idx_q + IDX_ONE;
      end
    end else begin
      rd_idx_d = rd_idx_q;
    end
  end

  // Control state registers; reset drops any partial frame.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_idx_q    <= IDX_ZERO;
      rd_idx_q    <= IDX_ZERO;
      prev_q      <= {DATA_WIDTH{1'b0}};
      order_err_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      prev_q      <= prev_d;
      order_err_q <= order_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule
